// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file port arbiter.
package regfile_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_t;

endpackage

// File: rtl/regfile_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a debug lock override; grant is combinational.
// Latency: zero cycles. Backpressure: the loser simply sees no grant.
module rr_arb2 (
    input  logic core_vld,
    input  logic dbg_vld,
    input  logic rr_last_dbg,
    input  logic lock,
    output logic gnt_core,
    output logic gnt_dbg
);

    always_comb begin
        gnt_core = 1'b0;
        gnt_dbg  = 1'b0;
        if (core_vld && dbg_vld) begin
            if (lock || !rr_last_dbg) begin
                gnt_dbg = 1'b1;
            end else begin
                gnt_core = 1'b1;
            end
        end else begin
            gnt_core = core_vld;
            gnt_dbg  = dbg_vld;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file between core and debug; sequences address setup before the write strobe.
// Latency: response two cycles after acceptance. Backpressure: ready only in IDLE, for the winner.
module regfile_port_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic              core_req_we,
    input  logic [ADDR_W-1:0] core_req_raddr1,
    input  logic [ADDR_W-1:0] core_req_raddr2,
    input  logic [ADDR_W-1:0] core_req_waddr,
    input  logic [DATA_W-1:0] core_req_wdata,
    output logic              core_rsp_valid,
    output logic [DATA_W-1:0] core_rsp_rdata1,
    output logic [DATA_W-1:0] core_rsp_rdata2,

    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_we,
    input  logic [ADDR_W-1:0] dbg_req_raddr1,
    input  logic [ADDR_W-1:0] dbg_req_raddr2,
    input  logic [ADDR_W-1:0] dbg_req_waddr,
    input  logic [DATA_W-1:0] dbg_req_wdata,
    input  logic              dbg_lock,
    output logic              dbg_rsp_valid,
    output logic [DATA_W-1:0] dbg_rsp_rdata1,
    output logic [DATA_W-1:0] dbg_rsp_rdata2,

    output logic [ADDR_W-1:0] rf_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr2,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2
);

    state_t              state_q, state_d;
    req_t                rr_last_q, rr_last_d;
    req_t                owner_q, owner_d;
    logic                lock_held_q, lock_held_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   raddr1_q, raddr1_d;
    logic [ADDR_W-1:0]   raddr2_q, raddr2_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wen_q, wen_d;
    logic                core_rsp_valid_q, core_rsp_valid_d;
    logic [DATA_W-1:0]   core_rdata1_q, core_rdata1_d;
    logic [DATA_W-1:0]   core_rdata2_q, core_rdata2_d;
    logic                dbg_rsp_valid_q, dbg_rsp_valid_d;
    logic [DATA_W-1:0]   dbg_rdata1_q, dbg_rdata1_d;
    logic [DATA_W-1:0]   dbg_rdata2_q, dbg_rdata2_d;

    logic gnt_core, gnt_dbg;

    // The lock only overrides round-robin while debug still holds dbg_lock, so
    // dropping it hands the very next arbitration back to fair rotation.
    rr_arb2 u_arb (
        .core_vld    (core_req_valid),
        .dbg_vld     (dbg_req_valid),
        .rr_last_dbg (rr_last_q == REQ_DBG),
        .lock        (lock_held_q && dbg_lock),
        .gnt_core    (gnt_core),
        .gnt_dbg     (gnt_dbg)
    );

    assign core_req_ready = (state_q == IDLE) && gnt_core;
    assign dbg_req_ready  = (state_q == IDLE) && gnt_dbg;

    always_comb begin
        state_d          = state_q;
        rr_last_d        = rr_last_q;
        owner_d          = owner_q;
        lock_held_d      = lock_held_q;
        we_d             = we_q;
        raddr1_d         = raddr1_q;
        raddr2_d         = raddr2_q;
        waddr_d          = waddr_q;
        wdata_d          = wdata_q;
        wen_d            = 1'b0;
        core_rsp_valid_d = 1'b0;
        core_rdata1_d    = core_rdata1_q;
        core_rdata2_d    = core_rdata2_q;
        dbg_rsp_valid_d  = 1'b0;
        dbg_rdata1_d     = dbg_rdata1_q;
        dbg_rdata2_d     = dbg_rdata2_q;

        case (state_q)
            IDLE: begin
                if (!dbg_lock) lock_held_d = 1'b0;
                if (core_req_ready && core_req_valid) begin
                    owner_d   = REQ_CORE;
                    rr_last_d = REQ_CORE;
                    we_d      = core_req_we;
                    raddr1_d  = core_req_raddr1;
                    raddr2_d  = core_req_raddr2;
                    waddr_d   = core_req_waddr;
                    wdata_d   = core_req_wdata;
                    state_d   = SETUP;
                end else if (dbg_req_ready && dbg_req_valid) begin
                    owner_d   = REQ_DBG;
                    rr_last_d = REQ_DBG;
                    we_d      = dbg_req_we;
                    raddr1_d  = dbg_req_raddr1;
                    raddr2_d  = dbg_req_raddr2;
                    waddr_d   = dbg_req_waddr;
                    wdata_d   = dbg_req_wdata;
                    if (dbg_lock) lock_held_d = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                // Read data is captured here, before the strobe, so a read of the
                // register being written returns its old contents.
                if (owner_q == REQ_CORE) begin
                    core_rsp_valid_d = 1'b1;
                    core_rdata1_d    = rf_read_data1;
                    core_rdata2_d    = rf_read_data2;
                end else begin
                    dbg_rsp_valid_d  = 1'b1;
                    dbg_rdata1_d     = rf_read_data1;
                    dbg_rdata2_d     = rf_read_data2;
                end
                if (we_q) begin
                    wen_d   = 1'b1;
                    state_d = STROBE;
                end else begin
                    state_d = IDLE;
                end
            end
            STROBE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            rr_last_q        <= REQ_DBG;
            owner_q          <= REQ_CORE;
            lock_held_q      <= 1'b0;
            we_q             <= 1'b0;
            raddr1_q         <= '0;
            raddr2_q         <= '0;
            waddr_q          <= '0;
            wdata_q          <= '0;
            wen_q            <= 1'b0;
            core_rsp_valid_q <= 1'b0;
            core_rdata1_q    <= '0;
            core_rdata2_q    <= '0;
            dbg_rsp_valid_q  <= 1'b0;
            dbg_rdata1_q     <= '0;
            dbg_rdata2_q     <= '0;
        end else begin
            state_q          <= state_d;
            rr_last_q        <= rr_last_d;
            owner_q          <= owner_d;
            lock_held_q      <= lock_held_d;
            we_q             <= we_d;
            raddr1_q         <= raddr1_d;
            raddr2_q         <= raddr2_d;
            waddr_q          <= waddr_d;
            wdata_q          <= wdata_d;
            wen_q            <= wen_d;
            core_rsp_valid_q <= core_rsp_valid_d;
            core_rdata1_q    <= core_rdata1_d;
            core_rdata2_q    <= core_rdata2_d;
            dbg_rsp_valid_q  <= dbg_rsp_valid_d;
            dbg_rdata1_q     <= dbg_rdata1_d;
            dbg_rdata2_q     <= dbg_rdata2_d;
        end
    end

    assign rf_read_addr1   = raddr1_q;
    assign rf_read_addr2   = raddr2_q;
    assign rf_write_addr   = waddr_q;
    assign rf_write_data   = wdata_q;
    assign rf_write_enable = wen_q;
    assign core_rsp_valid  = core_rsp_valid_q;
    assign core_rsp_rdata1 = core_rdata1_q;
    assign core_rsp_rdata2 = core_rdata2_q;
    assign dbg_rsp_valid   = dbg_rsp_valid_q;
    assign dbg_rsp_rdata1  = dbg_rdata1_q;
    assign dbg_rsp_rdata2  = dbg_rdata2_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural edge-written register file.
module tb_regfile_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       core_req_valid = 1'b0, core_req_ready, core_req_we = 1'b0;
    logic [2:0] core_req_raddr1 = '0, core_req_raddr2 = '0, core_req_waddr = '0;
    logic [7:0] core_req_wdata = '0;
    logic       core_rsp_valid;
    logic [7:0] core_rsp_rdata1, core_rsp_rdata2;
    logic       dbg_req_valid = 1'b0, dbg_req_ready, dbg_req_we = 1'b0, dbg_lock = 1'b0;
    logic [2:0] dbg_req_raddr1 = '0, dbg_req_raddr2 = '0, dbg_req_waddr = '0;
    logic [7:0] dbg_req_wdata = '0;
    logic       dbg_rsp_valid;
    logic [7:0] dbg_rsp_rdata1, dbg_rsp_rdata2;
    logic [2:0] rf_read_addr1, rf_read_addr2, rf_write_addr;
    logic [7:0] rf_write_data, rf_read_data1, rf_read_data2;
    logic       rf_write_enable;

    logic [7:0] rfm [8] = '{8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00};
    int         we_rise = 0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         waited;

    regfile_port_arbiter dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_we(core_req_we), .core_req_raddr1(core_req_raddr1),
        .core_req_raddr2(core_req_raddr2), .core_req_waddr(core_req_waddr),
        .core_req_wdata(core_req_wdata), .core_rsp_valid(core_rsp_valid),
        .core_rsp_rdata1(core_rsp_rdata1), .core_rsp_rdata2(core_rsp_rdata2),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_we(dbg_req_we), .dbg_req_raddr1(dbg_req_raddr1),
        .dbg_req_raddr2(dbg_req_raddr2), .dbg_req_waddr(dbg_req_waddr),
        .dbg_req_wdata(dbg_req_wdata), .dbg_lock(dbg_lock),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata1(dbg_rsp_rdata1),
        .dbg_rsp_rdata2(dbg_rsp_rdata2),
        .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rf_read_data1 = rfm[rf_read_addr1];
    assign rf_read_data2 = rfm[rf_read_addr2];
    always @(posedge rf_write_enable) begin
        rfm[rf_write_addr] <= rf_write_data;
        we_rise <= we_rise + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one request and wait for acceptance; returns at the cycle after it.
    task automatic do_req(input bit is_dbg, input bit we, input logic [2:0] ra1,
                          input logic [2:0] ra2, input logic [2:0] wa,
                          input logic [7:0] wd, output int n_wait);
        bit done = 0;
        n_wait = 0;
        if (is_dbg) begin
            dbg_req_we = we; dbg_req_raddr1 = ra1; dbg_req_raddr2 = ra2;
            dbg_req_waddr = wa; dbg_req_wdata = wd; dbg_req_valid = 1'b1;
        end else begin
            core_req_we = we; core_req_raddr1 = ra1; core_req_raddr2 = ra2;
            core_req_waddr = wa; core_req_wdata = wd; core_req_valid = 1'b1;
        end
        while (!done && n_wait < 20) begin
            #1;
            done = is_dbg ? dbg_req_ready : core_req_ready;
            tick();
            if (!done) n_wait++;
        end
        if (!done) chk("req_timeout", 0, 1);
        if (is_dbg) dbg_req_valid = 1'b0;
        else        core_req_valid = 1'b0;
    endtask

    // Both requesters held valid; checks the order of grants and their spacing.
    task automatic collect(input string tag, input int n, input logic [7:0] exp_seq,
                           input int exp_gap);
        int got = 0;
        int last = -1;
        int budget = 0;
        while (got < n && budget < 60) begin
            #1;
            if (core_req_ready || dbg_req_ready) begin
                chk({tag, "_gnt"}, {31'd0, dbg_req_ready}, {31'd0, exp_seq[got]});
                if (last >= 0) chk({tag, "_gap"}, cyc - last, exp_gap);
                last = cyc;
                got++;
            end
            tick();
            budget++;
        end
        if (got < n) chk({tag, "_timeout"}, got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        chk("rst_wen", rf_write_enable, 0);
        chk("rst_rf_waddr", rf_write_addr, 0);
        chk("rst_rsp_valid", {core_rsp_valid, dbg_rsp_valid}, 0);
        chk("rst_rdata", {core_rsp_rdata1, dbg_rsp_rdata2}, 0);
        rst = 1'b0;
        tick();

        // Core read of r2/r5
        do_req(0, 0, 3'd2, 3'd5, 3'd0, 8'h00, waited);
        chk("rd_wait", waited, 0);
        chk("rd_raddr1", rf_read_addr1, 2);
        chk("rd_rsp_t1", core_rsp_valid, 0);
        tick();
        chk("rd_rsp_t2", core_rsp_valid, 1);
        chk("rd_rdata1", core_rsp_rdata1, 8'h11);
        chk("rd_rdata2", core_rsp_rdata2, 8'hA5);
        tick();
        chk("rd_rsp_t3", core_rsp_valid, 0);
        chk("rd_hold", core_rsp_rdata1, 8'h11);
        chk("rd_no_we", we_rise, 0);

        // Core write r3=0x3C, reading r3 in the same transaction
        do_req(0, 1, 3'd3, 3'd5, 3'd3, 8'h3C, waited);
        chk("wr_waddr", rf_write_addr, 3);
        chk("wr_wdata", rf_write_data, 8'h3C);
        chk("wr_wen_t1", rf_write_enable, 0);
        tick();
        chk("wr_wen_t2", rf_write_enable, 1);
        chk("wr_rsp", core_rsp_valid, 1);
        chk("wr_old", core_rsp_rdata1, 8'h00);
        tick();
        chk("wr_wen_t3", rf_write_enable, 0);
        chk("wr_rise", we_rise, 1);
        do_req(0, 0, 3'd3, 3'd2, 3'd0, 8'h00, waited);
        tick();
        chk("wr_readback", core_rsp_rdata1, 8'h3C);
        tick();

        // Round-robin: rr_last is core now, so dbg leads
        core_req_we = 0; dbg_req_we = 0;
        core_req_valid = 1; dbg_req_valid = 1;
        collect("rr", 4, 8'b0000_0101, 2);

        // Lock: rr_last is core, dbg wins and then keeps winning
        dbg_lock = 1;
        collect("lock", 3, 8'b0000_0111, 2);
        dbg_lock = 0;
        collect("unlock", 1, 8'b0000_0000, 2);
        core_req_valid = 0; dbg_req_valid = 0;
        tick();

        // Reset during the write strobe
        do_req(0, 1, 3'd2, 3'd5, 3'd6, 8'h77, waited);
        tick();
        chk("ab_wen_before", rf_write_enable, 1);
        chk("ab_rdata_before", core_rsp_rdata1, 8'h11);
        #1 rst = 1;
        #1;
        chk("ab_wen_now", rf_write_enable, 0);
        chk("ab_rsp_now", core_rsp_valid, 0);
        chk("ab_rdata_clr", core_rsp_rdata1, 0);
        chk("ab_waddr_clr", rf_write_addr, 0);
        repeat (2) @(posedge clk);
        #3;
        chk("ab_rsp_held", core_rsp_valid, 0);
        rst = 0;
        core_req_valid = 1; dbg_req_valid = 1;
        collect("ab_first", 1, 8'b0000_0000, 2);
        core_req_valid = 0; dbg_req_valid = 0;
        tick();

        // Core write of r4 then dbg read of r4
        do_req(0, 1, 3'd0, 3'd0, 3'd4, 8'h5A, waited);
        do_req(1, 0, 3'd4, 3'd2, 3'd0, 8'h00, waited);
        chk("b2b_wait", waited, 2);
        tick();
        chk("b2b_rsp", dbg_rsp_valid, 1);
        chk("b2b_rdata1", dbg_rsp_rdata1, 8'h5A);
        chk("b2b_rdata2", dbg_rsp_rdata2, 8'h11);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
